// File: rtl/decoder_pulse.sv
// decoder_pulse: handshaked binary-to-one-hot decoder driving a timed pulse followed by an optional idle gap
module decoder_pulse #(
  parameter int IN_W = 3,
  parameter int NOUT = 8,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN = 0,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in,
  output logic [NOUT-1:0] out,
  output logic            out_valid,
  output logic            err,
  output logic            busy
);
  localparam int MAXL = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
  localparam int CW = $clog2(MAXL) + 1;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [IN_W-1:0] r_code;
  logic w_last, w_hit, w_drive, w_acc;
  assign w_last = r_cnt == '0;
  assign w_acc = in_valid && in_ready;
  // next state and counter; pulse phase hands over to the gap phase only when a gap exists
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt - CW'(1);
    case (r_state)
      IDLE: begin
        w_state = w_acc ? DRIVE : IDLE;
        w_cnt = w_acc ? CW'(PULSE_LEN - 1) : r_cnt;
      end
      DRIVE: if (w_last) begin
        w_state = GAP_LEN > 0 ? GAP : IDLE;
        w_cnt = CW'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
      end
      GAP: w_state = w_last ? IDLE : GAP;
      default: begin
        w_state = IDLE;
        w_cnt = '0;
      end
    endcase
  end
  // state, counter and latched code; the code only changes on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_code <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      if (w_acc) r_code <= in;
    end
  end
  assign in_ready = r_state == IDLE;
  assign w_drive = r_state == DRIVE;
  assign w_hit = 32'(r_code) < NOUT;
  assign out_valid = w_drive;
  assign busy = r_state != IDLE;
  assign err = w_drive && !w_hit;
  assign out = (w_drive && w_hit ? NOUT'(1) << r_code : '0) ^ {NOUT{ACT_LOW}};
endmodule
